// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode. It queues fetched instructions,
// back-pressures fetch and drops stale responses after a redirect.
module fetch_queue #(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inst_signal_i,
   input  logic [31:0]      inst_i,
   input  logic [63:0]      inst_pc_i,
   input  logic             awaiting_i,
   input  logic             flush_i,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [31:0]      out_inst_o,
   output logic [63:0]      out_pc_o,
   output logic             fetch_hold_o,
   output logic [CNT_W-1:0] count_o,
   output logic             overflow_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      inst_q [DEPTH];
   logic [63:0]      pc_q   [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             drop_next_q, drop_next_d;
   logic             overflow_q, overflow_d;

   logic pop, push, full, live_pulse;

   assign full       = (count_q == CNT_W'(DEPTH));
   assign live_pulse = inst_signal_i & ~drop_next_q & ~flush_i;
   assign pop        = out_valid_o & out_ready_i & ~flush_i;
   assign push       = live_pulse & (~full | pop);

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      drop_next_d = drop_next_q;
      overflow_d  = overflow_q;
      if (flush_i) begin
         // A response already in flight belongs to the abandoned path.
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
         drop_next_d = awaiting_i;
      end else begin
         if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (inst_signal_i & drop_next_q)
            drop_next_d = 1'b0;
         if (live_pulse & ~push)
            overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         drop_next_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         drop_next_q <= drop_next_d;
         overflow_q  <= overflow_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (push) begin
         inst_q[wr_ptr_q] <= inst_i;
         pc_q[wr_ptr_q]   <= inst_pc_i;
      end
   end

   assign out_valid_o  = (count_q != '0);
   assign out_inst_o   = inst_q[rd_ptr_q];
   assign out_pc_o     = pc_q[rd_ptr_q];
   // One slot of headroom for a request fetch may already have issued.
   assign fetch_hold_o = (count_q >= CNT_W'(DEPTH - 1));
   assign count_o      = count_q;
   assign overflow_o   = overflow_q;

endmodule
